// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op codes, FSM states,
// the per-operation record captured at issue, and small op-class helpers.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int CNTW = $clog2(MULDIV_WIDTH + 1);

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  // Everything FIXUP needs to turn magnitudes back into architectural HI/LO.
  typedef struct packed {
    muldiv_op_t op;
    logic       negLo;
    logic       negHi;
    logic       divZero;
  } muldiv_rec_t;

  function automatic logic isDivOp(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic isSignedOp(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> mul/div sequencer bundle. master = pipeline side, slave = sequencer.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic             mfreq;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, srca, srcb, mthi, mtlo, mfreq,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo, mfreq,
    output hi, lo, busy, done, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on unsigned magnitudes.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register the results.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] opB,
  input  logic [WIDTH-1:0]   shiftQ,
  output logic [2*WIDTH-1:0] accNext,
  output logic [2*WIDTH-1:0] opBNext,
  output logic [WIDTH-1:0]   shiftQNext,
  output logic               qBit
);

  logic [WIDTH:0] remShift;
  logic [WIDTH:0] diff;

  always_comb begin
    remShift   = {acc[WIDTH-1:0], shiftQ[WIDTH-1]};
    diff       = remShift - {1'b0, opB[WIDTH-1:0]};
    accNext    = acc;
    opBNext    = opB;
    shiftQNext = shiftQ;
    qBit       = 1'b0;
    if (isDiv) begin
      // remShift < 2*divisor, so the top bit of diff is a clean borrow flag.
      qBit       = ~diff[WIDTH];
      accNext    = {{WIDTH{1'b0}}, (qBit ? diff[WIDTH-1:0] : remShift[WIDTH-1:0])};
      shiftQNext = {shiftQ[WIDTH-2:0], 1'b0};
    end else begin
      if (shiftQ[0]) begin
        accNext = acc + opB;
      end
      opBNext    = opB << 1;
      shiftQNext = shiftQ >> 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: bit-serial MULT/MULTU/DIV/DIVU sequencer plus MTHI/MTLO writes. Optional MULDIV_EARLY_OUT_EN.
// Latency: WIDTH+1 cycles issue-to-HI/LO (multiply may finish early with MULDIV_EARLY_OUT_EN).
// Backpressure: stall while busy for start/mthi/mtlo/mfreq; the pipeline re-presents them.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  muldiv_state_t      state;
  muldiv_rec_t        rec;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] accReg;
  logic [2*WIDTH-1:0] bReg;
  logic [WIDTH-1:0]   qReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               busyReg;
  logic               doneReg;

  logic               isSigned;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] bNext;
  logic [WIDTH-1:0]   qNext;
  logic               qBit;
  logic               earlyOut;

  always_comb begin
    isSigned = isSignedOp(bus.op);
    magA     = (isSigned && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    magB     = (isSigned && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv      (isDivOp(rec.op)),
    .acc        (accReg),
    .opB        (bReg),
    .shiftQ     (qReg),
    .accNext    (accNext),
    .opBNext    (bNext),
    .shiftQNext (qNext),
    .qBit       (qBit)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // Remaining multiplier bits all zero: further iterations cannot change the product.
  assign earlyOut = !isDivOp(rec.op) && (qNext == '0);
`else
  assign earlyOut = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rec     <= '0;
      cnt     <= '0;
      accReg  <= '0;
      bReg    <= '0;
      qReg    <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            rec.op      <= bus.op;
            rec.negLo   <= isSigned && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            rec.negHi   <= isSigned && bus.srca[WIDTH-1];
            rec.divZero <= (bus.srcb == '0);
            accReg      <= '0;
            // Multiply: bReg = multiplicand, qReg = multiplier. Divide: bReg = divisor, qReg = dividend.
            bReg        <= {{WIDTH{1'b0}}, (isDivOp(bus.op) ? magB : magA)};
            qReg        <= isDivOp(bus.op) ? magA : magB;
            cnt         <= CNTW'(WIDTH);
            busyReg     <= 1'b1;
            state       <= RUN;
          end else begin
            if (bus.mthi) hiReg <= bus.srca;
            if (bus.mtlo) loReg <= bus.srca;
          end
        end
        RUN: begin
          accReg <= accNext;
          bReg   <= bNext;
          qReg   <= isDivOp(rec.op) ? {qNext[WIDTH-1:1], qBit} : qNext;
          cnt    <= cnt - CNTW'(1);
          if ((cnt == CNTW'(1)) || earlyOut) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (isDivOp(rec.op)) begin
            // Divide-by-zero leaves all-ones quotient; remainder sign fix restores the raw dividend.
            loReg <= rec.divZero ? '1 : (rec.negLo ? -qReg : qReg);
            hiReg <= rec.negHi ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
          end else begin
            {hiReg, loReg} <= rec.negLo ? -accReg : accReg;
          end
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;
  assign bus.busy  = busyReg;
  assign bus.done  = doneReg;
  assign bus.stall = busyReg && (bus.start || bus.mfreq || bus.mthi || bus.mtlo);

endmodule
